// File: rtl/cla_serial_pkg.sv
// Shared types and sizing helpers for the nibble-serial CLA adder.
package cla_serial_pkg;

   // Sequencer states: wait for a request, walk the slices, present the result.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Bits handled by one carry-lookahead slice per cycle.
   localparam int unsigned NIB_W = 4;

   // Slice-counter width for a given slice count; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

   // Slice-counter width for the default 32-bit operand.
   localparam int unsigned CNT_W = cnt_width(32 / NIB_W);

endpackage

// File: rtl/CLA_add4.sv
// 4-bit carry-lookahead slice with group generate/propagate outputs.
module CLA_add4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       gm_o,
   output logic       pm_o
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   // Bit generate/propagate, lookahead carries and group terms.
   always_comb begin
      g    = a_i & b_i;
      p    = a_i ^ b_i;
      c[0] = c_i;
      c[1] = g[0] | (p[0] & c_i);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
      s_o  = p ^ c;
      gm_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pm_o = &p;
   end

endmodule

// File: rtl/cla_serial_add32.sv
// Nibble-serial adder/subtractor: one CLA slice per cycle, LSB first, start/done handshake.
module cla_serial_add32
   import cla_serial_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             zero_o
);

   localparam int unsigned Nib  = WIDTH / NIB_W;
   localparam int unsigned CntW = cnt_width(Nib);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  opa_q, opa_d;
   logic [WIDTH-1:0]  opb_q, opb_d;
   logic              sign_a_q, sign_a_d;
   logic              sign_b_q, sign_b_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;

   logic [NIB_W-1:0]  slice_a, slice_b, slice_sum;
   logic              slice_gm, slice_pm;

   assign slice_a = opa_q[NIB_W*int'(cnt_q) +: NIB_W];
   assign slice_b = opb_q[NIB_W*int'(cnt_q) +: NIB_W];

   CLA_add4 u_slice (
      .a_i  (slice_a),
      .b_i  (slice_b),
      .c_i  (carry_q),
      .s_o  (slice_sum),
      .gm_o (slice_gm),
      .pm_o (slice_pm)
   );

   // Sequencer: accept operands, write one slice per cycle, register flags on the last one.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d  = StRun;
               opa_d    = a_i;
               // Subtraction as a + ~b + 1: invert b and seed the carry.
               opb_d    = sub_i ? ~b_i : b_i;
               carry_d  = sub_i;
               cnt_d    = '0;
               sign_a_d = a_i[WIDTH-1];
               sign_b_d = opb_d[WIDTH-1];
               result_d = '0;
            end
         end
         StRun: begin
            result_d[NIB_W*int'(cnt_q) +: NIB_W] = slice_sum;
            // Slice carry-out rebuilt from group generate/propagate.
            carry_d = slice_gm | (slice_pm & carry_q);
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntW'(Nib - 1)) begin
               state_d = StDone;
               cnt_d   = '0;
               cout_d  = carry_d;
               ovf_d   = (sign_a_q == sign_b_q) && (result_d[WIDTH-1] != sign_a_q);
               zero_d  = ~|result_d;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign busy_o   = (state_q == StRun);
   assign done_o   = (state_q == StDone);
   assign result_o = result_q;
   assign cout_o   = cout_q;
   assign ovf_o    = ovf_q;
   assign zero_o   = zero_q;

endmodule
